// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with atomic lock in front of a single-port data memory.
// Grants are combinational. Responses (rvalid/rdata/err) are registered one cycle after the grant.
module dmem_arbiter #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WIDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              gnt0_c, gnt1_c;
    logic              aerr0_c, aerr1_c;
    logic              rvalid0_q, rvalid1_q;
    logic              err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // Misaligned byte address or word index beyond the memory.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= WIDX_W'(DEPTH));
    endfunction

    assign aerr0_c = addr_err(addr0);
    assign aerr1_c = addr_err(addr1);

    // Grant selection, round-robin pointer and ownership next state.
    always_comb begin
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    if (!rr_q) gnt0_c = 1'b1;
                    else       gnt1_c = 1'b1;
                    rr_d = ~rr_q;
                end else begin
                    gnt0_c = req0;
                    gnt1_c = req1;
                end
            end
            OWN0:    gnt0_c = req0;
            OWN1:    gnt1_c = req1;
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
        if (gnt0_c) begin
            state_d = lock0 ? OWN0 : IDLE;
        end else if (gnt1_c) begin
            state_d = lock1 ? OWN1 : IDLE;
        end else if (state_q == OWN0 && !req0 && !lock0) begin
            state_d = IDLE;
        end else if (state_q == OWN1 && !req1 && !lock1) begin
            state_d = IDLE;
        end
    end

    assign gnt0 = gnt0_c;
    assign gnt1 = gnt1_c;

    // Memory port mux; errored writes never reach the memory.
    always_comb begin
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (gnt0_c) begin
            mem_write      = we0 && !aerr0_c;
            mem_address    = addr0;
            mem_write_data = wdata0;
        end else if (gnt1_c) begin
            mem_write      = we1 && !aerr1_c;
            mem_address    = addr1;
            mem_write_data = wdata1;
        end
    end

    // State, pointer and one-cycle response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            rvalid0_q <= gnt0_c;
            rvalid1_q <= gnt1_c;
            err0_q    <= gnt0_c && aerr0_c;
            err1_q    <= gnt1_c && aerr1_c;
            if (gnt0_c) rdata0_q <= (!we0 && !aerr0_c) ? mem_read_data : '0;
            if (gnt1_c) rdata1_q <= (!we1 && !aerr1_c) ? mem_read_data : '0;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Memory model: preset contents, then write on rising edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[0]   <= 32'hA0A0_A0A0;
        mem[1]   <= 32'hB1B1_B1B1;
        mem[8]   <= 32'h0000_0077;
        mem[255] <= 32'hCAFE_F00D;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_address[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Reset: a pending write request must not reach the memory.
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'h5555_5555;
        #3;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;

        // Write then read back on port 0.
        tick();
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        #1;
        chk("wr_gnt0", 32'(gnt0), 32'd1);
        chk("wr_mem_write", 32'(mem_write), 32'd1);
        chk("wr_mem_address", mem_address, 32'h10);
        chk("wr_mem_wdata", mem_write_data, 32'hDEAD_BEEF);
        tick();
        we0 = 0;
        #1;
        chk("rd_gnt0", 32'(gnt0), 32'd1);
        chk("rd_mem_write", 32'(mem_write), 32'd0);
        chk("wr_rvalid0", 32'(rvalid0), 32'd1);
        chk("wr_rdata0", rdata0, 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("idle_gnt0", 32'(gnt0), 32'd0);
        chk("idle_mem_address", mem_address, 32'd0);
        chk("rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        chk("rd_err0", 32'(err0), 32'd0);
        tick();
        #1;
        chk("hold_rvalid0", 32'(rvalid0), 32'd0);
        chk("hold_rdata0", rdata0, 32'hDEAD_BEEF);

        // Contested reads alternate starting with port 0.
        tick();
        req0 = 1; addr0 = 32'h0; req1 = 1; addr1 = 32'h4;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                #1;
            end
            chk("rr_gnt0", 32'(gnt0), 32'((k % 2) == 0));
            chk("rr_gnt1", 32'(gnt1), 32'((k % 2) == 1));
            if (k > 0) begin
                chk("rr_rvalid0", 32'(rvalid0), 32'((k % 2) == 1));
                chk("rr_rvalid1", 32'(rvalid1), 32'((k % 2) == 0));
                if ((k % 2) == 1) chk("rr_rdata0", rdata0, 32'hA0A0_A0A0);
                else              chk("rr_rdata1", rdata1, 32'hB1B1_B1B1);
            end
        end
        tick();
        clear_inputs();
        #1;
        chk("rr_last_rvalid1", 32'(rvalid1), 32'd1);
        chk("rr_last_rdata1", rdata1, 32'hB1B1_B1B1);
        chk("rr_last_rvalid0", 32'(rvalid0), 32'd0);

        // Locked read-modify-write on port 1 holds off port 0.
        tick();
        req1 = 1; lock1 = 1; addr1 = 32'h20;
        #1;
        chk("lk1_gnt1", 32'(gnt1), 32'd1);
        chk("lk1_gnt0", 32'(gnt0), 32'd0);
        tick();
        lock1 = 0; we1 = 1; wdata1 = 32'h5;
        req0 = 1; addr0 = 32'h20;
        #1;
        chk("lk2_gnt1", 32'(gnt1), 32'd1);
        chk("lk2_gnt0", 32'(gnt0), 32'd0);
        chk("lk2_mem_write", 32'(mem_write), 32'd1);
        chk("lk2_rvalid1", 32'(rvalid1), 32'd1);
        chk("lk2_rdata1", rdata1, 32'h77);
        tick();
        req1 = 0; we1 = 0; wdata1 = 0; addr1 = 0;
        #1;
        chk("lk3_gnt0", 32'(gnt0), 32'd1);
        chk("lk3_mem_address", mem_address, 32'h20);
        chk("lk3_rdata1", rdata1, 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("lk4_rvalid0", 32'(rvalid0), 32'd1);
        chk("lk4_rdata0", rdata0, 32'h5);

        // Out-of-range write is suppressed and flagged.
        tick();
        req0 = 1; we0 = 1; addr0 = 32'h400; wdata0 = 32'h1234_5678;
        #1;
        chk("oor_gnt0", 32'(gnt0), 32'd1);
        chk("oor_mem_write", 32'(mem_write), 32'd0);
        tick();
        we0 = 0; addr0 = 32'h3FC; wdata0 = 0;
        #1;
        chk("oor_rvalid0", 32'(rvalid0), 32'd1);
        chk("oor_err0", 32'(err0), 32'd1);
        chk("oor_rdata0", rdata0, 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("w255_err0", 32'(err0), 32'd0);
        chk("w255_rdata0", rdata0, 32'hCAFE_F00D);

        // Misaligned read on port 1.
        tick();
        req1 = 1; addr1 = 32'h6;
        #1;
        chk("mis_gnt1", 32'(gnt1), 32'd1);
        chk("mis_mem_write", 32'(mem_write), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("mis_rvalid1", 32'(rvalid1), 32'd1);
        chk("mis_err1", 32'(err1), 32'd1);
        chk("mis_rdata1", rdata1, 32'd0);

        // Reset right after a locked contested grant clears state and pointer.
        tick();
        req0 = 1; lock0 = 1; req1 = 1; addr1 = 32'h4;
        #1;
        chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
        tick();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("async_rvalid0", 32'(rvalid0), 32'd0);
        chk("async_gnt0", 32'(gnt0), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        req1 = 1; addr1 = 32'h4;
        #1;
        chk("post_rst_idle_gnt1", 32'(gnt1), 32'd1);
        tick();
        req0 = 1; addr0 = 32'h0;
        #1;
        chk("post_rst_rr_gnt0", 32'(gnt0), 32'd1);
        chk("post_rst_rr_gnt1", 32'(gnt1), 32'd0);
        tick();
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
